// File: rtl/seq_match_frame_counter_pkg.sv
// ============================================================================
// Module   : seq_match_pkg
// Brief    : Shared types and the saturating increment helper for the frame counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_match_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int unsigned C_CNT_W = 8;
    localparam int unsigned C_ID_W  = 8;
    localparam int unsigned C_FN_W  = 32;

    // Per-frame result in the default configuration; FIFO entries use the same field order.
    typedef struct packed {
        logic [C_CNT_W-1:0] count;
        logic               sat;
        logic [C_ID_W-1:0]  id;
    } result_t;

    function automatic logic [C_FN_W-1:0] sat_inc(
        input logic [C_FN_W-1:0] acc,
        input logic              inc,
        input logic [C_FN_W-1:0] max_val
    );
        if (inc && (acc != max_val)) begin
            return acc + 32'd1;
        end
        return acc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_match_frame_counter_if.sv
// ============================================================================
// Module   : seq_match_frame_counter_if
// Brief    : Valid/ready result channel from the frame counter to its consumer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_match_frame_counter_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ID_W  = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;
    logic [ID_W-1:0]  out_id;

    modport master (
        output out_valid,
        output out_count,
        output out_sat,
        output out_id,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_count,
        input  out_sat,
        input  out_id,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/seq_result_fifo.sv
// ============================================================================
// Module   : seq_result_fifo
// Brief    : First-word fall-through result FIFO; a push into a full FIFO only
//            lands when a pop frees a slot on the same edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_result_fifo #(
    parameter int unsigned DATA_W = 17,
    parameter int unsigned DEPTH  = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              push_i,
    input  wire logic              pop_i,
    input  wire logic [DATA_W-1:0] wr_data_i,
    output logic      [DATA_W-1:0] rd_data_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int unsigned C_PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [C_PTR_W:0]   wr_ptr_q;
    logic [C_PTR_W:0]   rd_ptr_q;
    logic               w_wr_en;
    logic               w_rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[C_PTR_W] != rd_ptr_q[C_PTR_W]) &&
                     (wr_ptr_q[C_PTR_W-1:0] == rd_ptr_q[C_PTR_W-1:0]);

    assign w_rd_en = pop_i && !empty_o;
    assign w_wr_en = push_i && (!full_o || w_rd_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_wr_en) begin
                wr_ptr_q <= wr_ptr_q + (C_PTR_W+1)'(1);
            end
            if (w_rd_en) begin
                rd_ptr_q <= rd_ptr_q + (C_PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q[C_PTR_W-1:0]] <= wr_data_i;
        end
    end

    // Head reads as zero while empty so the outputs are quiet after reset.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[C_PTR_W-1:0]];

endmodule

`default_nettype wire

// File: rtl/seq_match_frame_counter.sv
// ============================================================================
// Module   : seq_match_frame_counter
// Brief    : Counts detector match pulses per fixed-length frame and queues
//            {count, sat, id} results for a valid/ready consumer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_match_frame_counter
    import seq_match_pkg::*;
#(
    parameter int unsigned FRAME_LEN  = 64,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned ID_W       = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic start_i,
    input  wire logic in_en_i,
    input  wire logic match_i,
    output logic      overflow_o,
    output logic      busy_o,
    seq_match_frame_counter_if.master res_if
);
    localparam int unsigned      C_BIT_W = $clog2(FRAME_LEN);
    localparam int unsigned      C_RES_W = CNT_W + 1 + ID_W;
    localparam logic [C_BIT_W-1:0] C_LAST = C_BIT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]   C_MAX  = '1;

    state_t             state_q, state_d;
    logic [C_BIT_W-1:0] bit_q, bit_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic               sat_q, sat_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               overflow_q;

    logic [CNT_W-1:0]   w_acc_inc;
    logic               w_sat_hit;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [C_RES_W-1:0] w_wr_data;
    logic [C_RES_W-1:0] w_rd_data;

    assign w_acc_inc = CNT_W'(sat_inc(C_FN_W'(acc_q), match_i, C_FN_W'(C_MAX)));
    assign w_sat_hit = match_i && (acc_q == C_MAX);
    assign w_wr_data = {w_acc_inc, sat_q | w_sat_hit, id_q};

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        id_d    = id_q;
        w_push  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = COUNT;
                    bit_d   = C_BIT_W'(in_en_i);
                    acc_d   = CNT_W'(in_en_i && match_i);
                    sat_d   = 1'b0;
                end
            end
            COUNT: begin
                // Closing bit takes priority over a coincident start.
                if (in_en_i && (bit_q == C_LAST)) begin
                    w_push = 1'b1;
                    bit_d  = '0;
                    acc_d  = '0;
                    sat_d  = 1'b0;
                    id_d   = id_q + ID_W'(1);
                end else if (start_i) begin
                    bit_d = C_BIT_W'(in_en_i);
                    acc_d = CNT_W'(in_en_i && match_i);
                    sat_d = 1'b0;
                end else if (in_en_i) begin
                    bit_d = bit_q + C_BIT_W'(1);
                    acc_d = w_acc_inc;
                    sat_d = sat_q | w_sat_hit;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            id_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            id_q    <= id_d;
            if (w_push && w_full && !w_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    seq_result_fifo #(
        .DATA_W (C_RES_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (w_push),
        .pop_i     (w_pop),
        .wr_data_i (w_wr_data),
        .rd_data_o (w_rd_data),
        .empty_o   (w_empty),
        .full_o    (w_full)
    );

    assign w_pop            = !w_empty && res_if.out_ready;
    assign res_if.out_valid = !w_empty;
    assign res_if.out_count = w_rd_data[C_RES_W-1 -: CNT_W];
    assign res_if.out_sat   = w_rd_data[ID_W];
    assign res_if.out_id    = w_rd_data[ID_W-1:0];
    assign overflow_o       = overflow_q;
    assign busy_o           = (state_q == COUNT);

endmodule

`default_nettype wire

// File: tb/tb_seq_match_frame_counter.sv
// ============================================================================
// Module   : tb_seq_match_frame_counter
// Brief    : Directed bench: FRAME_LEN=8, CNT_W=2, ID_W=8, FIFO_DEPTH=2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_match_frame_counter;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic in_en;
    logic match;
    logic overflow;
    logic busy;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    seq_match_frame_counter_if #(.CNT_W(2), .ID_W(8)) res_if ();

    seq_match_frame_counter #(
        .FRAME_LEN  (8),
        .CNT_W      (2),
        .ID_W       (8),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .in_en_i    (in_en),
        .match_i    (match),
        .overflow_o (overflow),
        .busy_o     (busy),
        .res_if     (res_if.master)
    );

    task automatic step(input logic s, input logic e, input logic m);
        start = s;
        in_en = e;
        match = m;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic s0, input logic [7:0] mask, input logic rdy_last);
        for (int k = 0; k < 8; k++) begin
            if (k == 7 && rdy_last) res_if.out_ready = 1'b1;
            step((k == 0) ? s0 : 1'b0, 1'b1, mask[k]);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_en = 1'b0; match = 1'b0;
        res_if.out_ready = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        rst = 1'b0;
        check("rst_valid", res_if.out_valid, 0);
        check("rst_count", res_if.out_count, 0);
        check("rst_sat",   res_if.out_sat,   0);
        check("rst_id",    res_if.out_id,    0);
        check("rst_ovf",   overflow,         0);
        check("rst_busy",  busy,             0);

        // Basic: matches at bits 3 and 7
        step(1, 1, 0);
        for (int k = 1; k < 7; k++) step(0, 1, (k == 3));
        check("basic_busy",      busy,             1);
        check("basic_pre_valid", res_if.out_valid, 0);
        step(0, 1, 1);
        check("basic_valid", res_if.out_valid, 1);
        check("basic_count", res_if.out_count, 2);
        check("basic_sat",   res_if.out_sat,   0);
        check("basic_id",    res_if.out_id,    0);
        step(0, 0, 0);
        check("basic_pop", res_if.out_valid, 0);

        // Saturation
        frame(0, 8'hFF, 0);
        check("sat_count", res_if.out_count, 3);
        check("sat_sat",   res_if.out_sat,   1);
        check("sat_id",    res_if.out_id,    1);
        step(0, 0, 0);

        // Gaps: unqualified matches are ignored; qualified match only at bit 1
        for (int i = 0; i < 14; i++) step(0, (i % 2 == 0), (i % 2 == 1) || (i == 2));
        check("gap_pre_valid", res_if.out_valid, 0);
        step(0, 1, 0);
        check("gap_valid", res_if.out_valid, 1);
        check("gap_count", res_if.out_count, 1);
        check("gap_id",    res_if.out_id,    2);
        step(0, 0, 0);

        // Restart mid-frame: old bit-1 match discarded
        for (int k = 0; k < 5; k++) step(0, 1, (k == 1));
        step(1, 1, 1);
        check("rs_no_push", res_if.out_valid, 0);
        for (int k = 1; k < 8; k++) step(0, 1, (k == 4));
        check("rs_count", res_if.out_count, 2);
        check("rs_id",    res_if.out_id,    3);

        // Start on the closing bit: close wins, next frame starts next bit
        for (int k = 0; k < 7; k++) step(0, 1, (k == 2));
        step(1, 1, 1);
        check("rsc_valid", res_if.out_valid, 1);
        check("rsc_count", res_if.out_count, 2);
        check("rsc_id",    res_if.out_id,    4);
        for (int k = 0; k < 7; k++) step(0, 1, (k == 0));
        check("rsc_next_pre", res_if.out_valid, 0);
        step(0, 1, 0);
        check("rsc_next_count", res_if.out_count, 1);
        check("rsc_next_id",    res_if.out_id,    5);
        step(0, 0, 0);

        // Backpressure: three frames with out_ready=0
        res_if.out_ready = 1'b0;
        frame(0, 8'h01, 0);
        check("bp_id6", res_if.out_id, 6);
        for (int k = 0; k < 4; k++) step(0, 1, 0);
        check("bp_hold_id",    res_if.out_id,    6);
        check("bp_hold_count", res_if.out_count, 1);
        for (int k = 4; k < 8; k++) step(0, 1, 0);
        check("bp_full_ovf", overflow, 0);
        frame(0, 8'hFF, 0);
        check("bp_drop_ovf", overflow,         1);
        check("bp_drop_id",  res_if.out_id,    6);
        res_if.out_ready = 1'b1;
        step(0, 0, 0);
        check("bp_id7",    res_if.out_id,    7);
        check("bp_cnt7",   res_if.out_count, 0);
        step(0, 0, 0);
        check("bp_empty",  res_if.out_valid, 0);
        frame(0, 8'h80, 0);
        check("bp_id9",    res_if.out_id,    9);
        check("bp_cnt9",   res_if.out_count, 1);
        step(0, 0, 0);

        // Full FIFO, ready raised on the closing edge: push and pop both land
        res_if.out_ready = 1'b0;
        frame(0, 8'h00, 0);
        frame(0, 8'h02, 0);
        frame(0, 8'h03, 1);
        check("pp_id11",  res_if.out_id,    11);
        check("pp_cnt11", res_if.out_count, 1);
        step(0, 0, 0);
        check("pp_valid12", res_if.out_valid, 1);
        check("pp_id12",    res_if.out_id,    12);
        check("pp_cnt12",   res_if.out_count, 2);
        step(0, 0, 0);
        check("pp_empty", res_if.out_valid, 0);
        check("pp_ovf",   overflow,         1);

        // Reset mid-frame with one entry queued
        res_if.out_ready = 1'b0;
        frame(0, 8'h00, 0);
        check("mr_queued", res_if.out_valid, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 1);
        rst = 1'b1;
        step(0, 1, 1);
        rst = 1'b0;
        check("mr_valid", res_if.out_valid, 0);
        check("mr_ovf",   overflow,         0);
        check("mr_busy",  busy,             0);
        check("mr_id",    res_if.out_id,    0);
        for (int k = 0; k < 8; k++) step(0, 1, 1);
        check("mr_idle_valid", res_if.out_valid, 0);
        check("mr_idle_busy",  busy,             0);
        frame(1, 8'h01, 0);
        check("mr_new_valid", res_if.out_valid, 1);
        check("mr_new_id",    res_if.out_id,    0);
        check("mr_new_count", res_if.out_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_match_frame_counter.md
Name: seq_match_frame_counter

Overview:
- Downstream consumer of the Mealy non-overlapping sequence detector's z output.
- Splits the detector's bit stream into fixed-length frames and counts match pulses per frame.
- Buffers each per-frame result (count, saturation flag, frame id) in a small FIFO.
- Presents results to a host/logger over a valid/ready handshake.

Parameters:
FRAME_LEN, 64, bit positions per frame (>=2)
CNT_W, 8, width of per-frame match count
ID_W, 8, width of frame id (wraps)
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  (re)align frame: the current cycle is bit 0 of a new frame
in_en  in  1  bit position qualifier; 1 = this cycle is one detector bit
match  in  1  detector z; sampled only when in_en=1
out_valid  out  1  FIFO head holds a result
out_ready  in  1  consumer accepts head
out_count  out  CNT_W  matches in frame at head
out_sat  out  1  count saturated in that frame
out_id  out  ID_W  frame id of head
overflow  out  1  sticky; a completed frame was dropped because the FIFO was full
busy  out  1  FSM in COUNT

Behaviour:
- Reset (rst=1 at edge): FSM=IDLE; bit_idx=0, acc=0, sat=0, frame id=0, FIFO empty, overflow=0. All outputs 0 the cycle after. rst mid-frame discards partial frame and all FIFO contents.
- FSM states:
  - IDLE: ignore in_en/match. start=1 -> COUNT. That same cycle is processed as bit 0 if in_en=1.
  - COUNT: each cycle with in_en=1 advances bit_idx. match=1 with in_en=1 increments acc, saturating at 2^CNT_W-1; saturating sets sat. match with in_en=0 is ignored.
- Frame close: in_en=1 and bit_idx==FRAME_LEN-1.
  - Result = {acc+match (saturating), sat, id} is pushed.
  - bit_idx, acc and sat clear on the same edge; id increments (wraps mod 2^ID_W).
  - FSM stays in COUNT; frames are back-to-back.
- start while in COUNT: partial frame discarded (no push, id unchanged); realign as bit 0 this cycle.
  - start coincident with frame close: the close wins and the frame is pushed; the new frame begins next bit.
- FIFO: first-word fall-through. Push at edge E gives out_valid=1 after E (1-cycle latency).
  - Pop when out_valid && out_ready.
  - out_* stable while out_valid=1 && out_ready=0.
- Full: push with FIFO full and no pop on the same edge -> result dropped, overflow<=1 (cleared only by rst), id still increments.
  - Push and pop on the same edge when full -> both succeed, level unchanged.
- Push and pop on the same edge when empty is impossible (FWFT latency); head updates next cycle.

Decomposition:
- Package seq_match_pkg:
  - FSM state enum {IDLE, COUNT}.
  - Result struct {count, sat, id}, parameterised via localparam defaults.
  - Function sat_inc(acc, inc).
- Sub-module seq_result_fifo: synchronous FWFT FIFO with push/pop/full/empty and the simultaneous full push+pop rule. The top instantiates it once.

Test Plan (FRAME_LEN=8, CNT_W=2, FIFO_DEPTH=2, out_ready=1 unless stated):
- Basic count: start, 8 cycles in_en=1, match at bits 3 and 7 -> one result count=2, sat=0, id=0; out_valid high exactly one cycle after the closing edge.
- Saturation: match on all 8 bits -> count=3, sat=1.
- Gaps: in_en pattern 1,0,1,... with match=1 on in_en=0 cycles -> those matches are ignored. The frame closes only after the 8th qualified bit.
- Restart: start at bit 5 -> no push, id unchanged. Next full frame reports id=0.
  - start on the closing bit -> frame pushed, next frame starts next bit.
- Backpressure: out_ready=0 for 3 frames -> first two held with stable outputs (ids 0, 1); third dropped, overflow=1; next kept frame has id=3.
  - Raising out_ready with a simultaneous push when full -> no drop.
- Reset: rst mid-frame with 1 entry queued -> out_valid=0, overflow=0 next cycle; FSM IDLE, in_en ignored until start.
